// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised up/down counter with wrap/saturate, load clamp, clear and boundary event
module updown_counter_n #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             match,
    output logic             bnd_evt,
    output logic             bnd_dir
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             bnd_evt_q, bnd_evt_d, bnd_dir_q, bnd_dir_d;
    logic             top, bot;

    assign top = count_q == MAX_VAL;
    assign bot = count_q == '0;

    always_comb begin
        count_d   = count_q;
        bnd_evt_d = 1'b0;
        bnd_dir_d = bnd_dir_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val > MAX_VAL ? MAX_VAL : load_val;
        end else if (en && up) begin
            count_d   = top ? (SATURATE ? MAX_VAL : '0) : count_q + 1'b1;
            bnd_evt_d = top;
            bnd_dir_d = top ? 1'b1 : bnd_dir_q;
        end else if (en) begin
            count_d   = bot ? (SATURATE ? '0 : MAX_VAL) : count_q - 1'b1;
            bnd_evt_d = bot;
            bnd_dir_d = bot ? 1'b0 : bnd_dir_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            bnd_evt_q <= 1'b0;
            bnd_dir_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            bnd_evt_q <= bnd_evt_d;
            bnd_dir_q <= bnd_dir_d;
        end
    end

    assign count   = count_q;
    assign at_max  = top;
    assign at_min  = bot;
    assign match   = count_q == cmp_val;
    assign bnd_evt = bnd_evt_q;
    assign bnd_dir = bnd_dir_q;
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: scoreboard bench over three counter configurations
module tb_updown_counter_n;
    localparam logic [2:0][3:0] MX  = {4'd9, 4'd15, 4'd9};
    localparam logic [2:0]      SAT = 3'b110;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       clr [3];
    logic       ld [3];
    logic [3:0] ldv [3];
    logic       en [3];
    logic       up [3];
    logic [3:0] cmp [3];
    logic [3:0] cnt [3];
    logic       amax [3];
    logic       amin [3];
    logic       mat [3];
    logic       evt [3];
    logic       dir [3];

    logic [3:0] ec [3];
    logic       ee [3];
    logic       ed [3];

    typedef struct packed {
        logic [2:0][3:0] c;
        logic [2:0]      e;
        logic [2:0]      d;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        updown_counter_n #(.WIDTH(4), .MAX_VAL(MX[g]), .SATURATE(SAT[g])) dut (
            .clk(clk), .reset_n(rst_n[g]), .clear(clr[g]), .load(ld[g]),
            .load_val(ldv[g]), .en(en[g]), .up(up[g]), .cmp_val(cmp[g]),
            .count(cnt[g]), .at_max(amax[g]), .at_min(amin[g]), .match(mat[g]),
            .bnd_evt(evt[g]), .bnd_dir(dir[g])
        );
    end

    task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] w);
        checks++;
        if (a !== w) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h at %0t", n, i, a, w, $time);
        end
    endtask

    task automatic push();
        exp_t x;
        for (int j = 0; j < 3; j++) begin
            x.c[j] = ec[j];
            x.e[j] = ee[j];
            x.d[j] = ed[j];
        end
        sb.push_back(x);
    endtask

    // Monitor: after every edge compare each DUT against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                for (int j = 0; j < 3; j++) begin
                    chk("count", j, 32'(cnt[j]), 32'(x.c[j]));
                    chk("bnd_evt", j, 32'(evt[j]), 32'(x.e[j]));
                    chk("bnd_dir", j, 32'(dir[j]), 32'(x.d[j]));
                    chk("at_max", j, 32'(amax[j]), 32'(x.c[j] == MX[j]));
                    chk("at_min", j, 32'(amin[j]), 32'(x.c[j] == 4'd0));
                    chk("match", j, 32'(mat[j]), 32'(x.c[j] == cmp[j]));
                end
            end
        end
    end

    task automatic rst_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                rst_n[j] = 1'b0; clr[j] = 1'b0; ld[j] = 1'b1; ldv[j] = 4'd5;
                en[j] = 1'b1; up[j] = 1'b1; cmp[j] = 4'd0;
                ec[j] = 4'd0; ee[j] = 1'b0; ed[j] = 1'b0;
            end
            push();
        end
    endtask

    // One directed edge on DUT i; the other DUTs idle and hold.
    task automatic drive(input int i, input bit rn, input bit cl, input bit l, input logic [3:0] lv,
                         input bit e, input bit u, input logic [3:0] cv,
                         input logic [3:0] xc, input bit xe, input bit xd);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = 1'b1; clr[j] = 1'b0; ld[j] = 1'b0; en[j] = 1'b0; ee[j] = 1'b0;
        end
        rst_n[i] = rn; clr[i] = cl; ld[i] = l; ldv[i] = lv; en[i] = e; up[i] = u; cmp[i] = cv;
        ec[i] = xc; ee[i] = xe; ed[i] = xd;
        push();
    endtask

    task automatic rnd();
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = $urandom_range(31) != 0;
            clr[j]   = $urandom_range(15) == 0;
            ld[j]    = $urandom_range(7) == 0;
            ldv[j]   = 4'($urandom_range(15));
            en[j]    = $urandom_range(3) != 0;
            up[j]    = $urandom_range(1) != 0;
            cmp[j]   = 4'($urandom_range(15));
            if (!rst_n[j]) begin
                ec[j] = 4'd0; ee[j] = 1'b0; ed[j] = 1'b0;
            end else if (clr[j]) begin
                ec[j] = 4'd0; ee[j] = 1'b0;
            end else if (ld[j]) begin
                ec[j] = ldv[j] > MX[j] ? MX[j] : ldv[j]; ee[j] = 1'b0;
            end else if (en[j] && up[j]) begin
                if (ec[j] == MX[j]) begin
                    ec[j] = SAT[j] ? MX[j] : 4'd0; ee[j] = 1'b1; ed[j] = 1'b1;
                end else begin
                    ec[j] = ec[j] + 4'd1; ee[j] = 1'b0;
                end
            end else if (en[j]) begin
                if (ec[j] == 4'd0) begin
                    ec[j] = SAT[j] ? 4'd0 : MX[j]; ee[j] = 1'b1; ed[j] = 1'b0;
                end else begin
                    ec[j] = ec[j] - 4'd1; ee[j] = 1'b0;
                end
            end else begin
                ee[j] = 1'b0;
            end
        end
        push();
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = 1'b0; clr[j] = 1'b0; ld[j] = 1'b0; ldv[j] = 4'd0;
            en[j] = 1'b0; up[j] = 1'b0; cmp[j] = 4'd0;
        end
        rst_cycles(2);
        // reset release counts immediately
        drive(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'd1, 0, 0);
        // wrap up through 9 -> 0, then down 0 -> 9
        drive(0, 1, 1, 0, 4'd0, 0, 0, 4'd0, 4'd0, 0, 0);
        for (int k = 1; k <= 10; k++)
            drive(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'(k % 10), k == 10, k == 10);
        drive(0, 1, 0, 0, 4'd0, 1, 0, 4'd0, 4'd9, 1, 0);
        // load clamp beats en; clear beats load
        drive(0, 1, 0, 1, 4'd12, 1, 1, 4'd0, 4'd9, 0, 0);
        drive(0, 1, 1, 1, 4'd5, 0, 0, 4'd0, 4'd0, 0, 0);
        // compare
        drive(0, 1, 0, 1, 4'd5, 0, 0, 4'd7, 4'd5, 0, 0);
        drive(0, 1, 0, 0, 4'd0, 1, 1, 4'd7, 4'd6, 0, 0);
        drive(0, 1, 0, 0, 4'd0, 1, 1, 4'd7, 4'd7, 0, 0);
        drive(0, 1, 0, 0, 4'd0, 1, 1, 4'd7, 4'd8, 0, 0);
        drive(0, 1, 0, 0, 4'd0, 0, 0, 4'd8, 4'd8, 0, 0);
        #1 chk("match_same_cycle", 0, 32'(mat[0]), 32'd1);
        // saturate up and down
        drive(1, 1, 0, 1, 4'd14, 0, 0, 4'd0, 4'd14, 0, 0);
        drive(1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'd15, 0, 0);
        drive(1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'd15, 1, 1);
        drive(1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'd15, 1, 1);
        drive(1, 1, 0, 1, 4'd1, 0, 0, 4'd0, 4'd1, 0, 1);
        drive(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 4'd0, 0, 1);
        drive(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 4'd0, 1, 0);
        drive(1, 1, 0, 0, 4'd0, 1, 0, 4'd0, 4'd0, 1, 0);
        // saturate at a non-power-of-two terminal, then reset mid-count
        drive(2, 1, 0, 1, 4'd12, 0, 0, 4'd0, 4'd9, 0, 0);
        drive(2, 1, 0, 0, 4'd0, 1, 1, 4'd0, 4'd9, 1, 1);
        drive(2, 0, 0, 0, 4'd0, 1, 1, 4'd0, 4'd0, 0, 0);
        drive(2, 1, 0, 0, 4'd0, 1, 0, 4'd0, 4'd0, 1, 0);
        repeat (10000) rnd();
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
